// File: rtl/fifo_tx_drain.sv
// fifo_tx_drain
// Pulls bytes one at a time from the receive buffer and offers each to the
// UART transmitter over a valid/ready handshake. A new read is started only
// when enabled, CTS is asserted and the buffer is non-empty. Once a byte has
// been requested it is always delivered. A read with no response raises a
// sticky timeout error.
//
// Ports
//   clk, rst                 system clock, async active-high reset
//   enable, cts_n            gate new fetches (cts_n active-low)
//   fifo_empty               buffer empty flag, looked at only in IDLE
//   fifo_rd_en               one-cycle read request (registered)
//   fifo_rd_data/_valid      read response from the buffer
//   tx_data, tx_valid        byte offered to the transmitter (registered)
//   tx_ready                 transmitter accepts the byte
//   busy                     any state other than IDLE
//   sent_count               bytes accepted by the transmitter, wraps
//   timeout_err, clr_err     sticky read-timeout flag and its clear
//
// state     | meaning
// IDLE      | waiting for enable && !cts_n && !fifo_empty
// FETCH     | fifo_rd_en high for this single cycle
// WAIT_DATA | waiting for fifo_rd_valid, counting toward timeout
// SEND      | tx_valid held until tx_ready
module fifo_tx_drain #(
  parameter int TIMEOUT_CYCLES = 16,
  parameter int COUNT_WIDTH    = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   enable,
  input  logic                   cts_n,
  input  logic                   fifo_empty,
  output logic                   fifo_rd_en,
  input  logic [7:0]             fifo_rd_data,
  input  logic                   fifo_rd_valid,
  output logic [7:0]             tx_data,
  output logic                   tx_valid,
  input  logic                   tx_ready,
  output logic                   busy,
  output logic [COUNT_WIDTH-1:0] sent_count,
  output logic                   timeout_err,
  input  logic                   clr_err
);

  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

  typedef enum logic [1:0] {
    S_IDLE      = 2'd0,
    S_FETCH     = 2'd1,
    S_WAIT_DATA = 2'd2,
    S_SEND      = 2'd3
  } state_t;

  state_t                 state_q, state_d;
  logic                   fifo_rd_en_q, fifo_rd_en_d;
  logic [7:0]             tx_data_q, tx_data_d;
  logic                   tx_valid_q, tx_valid_d;
  logic [COUNT_WIDTH-1:0] sent_count_q, sent_count_d;
  logic                   timeout_err_q, timeout_err_d;
  logic [TW-1:0]          tmo_q, tmo_d;

  logic [TW-1:0] tmo_inc;
  logic          tmo_hit;
  logic          handshake;

  assign tmo_inc   = tmo_q + TW'(1);
  // Timeout fires on the cycle the incremented count would reach the limit,
  // so the error flag lands exactly TIMEOUT_CYCLES edges after entering WAIT_DATA.
  assign tmo_hit   = (state_q == S_WAIT_DATA) && !fifo_rd_valid
                     && (tmo_inc == TW'(TIMEOUT_CYCLES));
  assign handshake = (state_q == S_SEND) && tx_valid_q && tx_ready;

  // State register and registered outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= S_IDLE;
      fifo_rd_en_q  <= 1'b0;
      tx_data_q     <= 8'h00;
      tx_valid_q    <= 1'b0;
      sent_count_q  <= '0;
      timeout_err_q <= 1'b0;
      tmo_q         <= '0;
    end else begin
      state_q       <= state_d;
      fifo_rd_en_q  <= fifo_rd_en_d;
      tx_data_q     <= tx_data_d;
      tx_valid_q    <= tx_valid_d;
      sent_count_q  <= sent_count_d;
      timeout_err_q <= timeout_err_d;
      tmo_q         <= tmo_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:      if (enable && !cts_n && !fifo_empty) state_d = S_FETCH;
      S_FETCH:     state_d = S_WAIT_DATA;
      S_WAIT_DATA: begin
        if (fifo_rd_valid) state_d = S_SEND;
        else if (tmo_hit)  state_d = S_IDLE;
      end
      S_SEND:      if (handshake) state_d = S_IDLE;
      default:     state_d = S_IDLE;
    endcase
  end

  // Output / datapath logic. Outputs are registered, so they are computed
  // from the state being entered.
  always_comb begin
    fifo_rd_en_d  = (state_d == S_FETCH);
    tx_valid_d    = (state_d == S_SEND);
    tx_data_d     = tx_data_q;
    sent_count_d  = sent_count_q;
    timeout_err_d = timeout_err_q;
    tmo_d         = tmo_q;

    if (state_q == S_FETCH) tmo_d = '0;
    else if (state_q == S_WAIT_DATA && !fifo_rd_valid) tmo_d = tmo_inc;

    if (state_q == S_WAIT_DATA && fifo_rd_valid) tx_data_d = fifo_rd_data;

    if (handshake) sent_count_d = sent_count_q + COUNT_WIDTH'(1);

    // Set takes priority over clear when both happen together.
    if (tmo_hit)      timeout_err_d = 1'b1;
    else if (clr_err) timeout_err_d = 1'b0;
  end

  assign fifo_rd_en  = fifo_rd_en_q;
  assign tx_data     = tx_data_q;
  assign tx_valid    = tx_valid_q;
  assign sent_count  = sent_count_q;
  assign timeout_err = timeout_err_q;
  assign busy        = (state_q != S_IDLE);

endmodule

// File: tb/tb_fifo_tx_drain.sv
module tb_fifo_tx_drain;
  localparam int CW = 4;
  localparam int TO = 16;

  logic          clk = 1'b0;
  logic          rst, enable, cts_n, fifo_empty, fifo_rd_en, fifo_rd_valid;
  logic          tx_valid, tx_ready, busy, timeout_err, clr_err;
  logic [7:0]    fifo_rd_data, tx_data;
  logic [CW-1:0] sent_count;

  fifo_tx_drain #(.TIMEOUT_CYCLES(TO), .COUNT_WIDTH(CW)) dut (
    .clk(clk), .rst(rst), .enable(enable), .cts_n(cts_n),
    .fifo_empty(fifo_empty), .fifo_rd_en(fifo_rd_en),
    .fifo_rd_data(fifo_rd_data), .fifo_rd_valid(fifo_rd_valid),
    .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
    .busy(busy), .sent_count(sent_count), .timeout_err(timeout_err),
    .clr_err(clr_err)
  );

  always #5 clk = ~clk;

  logic [7:0] q[$];
  logic [7:0] exp_q[$];
  logic [7:0] obs_q[$];
  bit         suppress;
  bit         pending;
  int         rd_pulses = 0;
  int         errors = 0;
  int         checks = 0;
  logic       prev_valid, prev_hs;
  logic [7:0] prev_data;

  // Buffer model: answers a read request one cycle after fifo_rd_en.
  always @(negedge clk) begin
    fifo_rd_valid = 1'b0;
    if (pending && q.size() > 0 && !rst) begin
      fifo_rd_data  = q.pop_front();
      fifo_rd_valid = 1'b1;
    end
    pending    = fifo_rd_en && !suppress && !rst;
    fifo_empty = (q.size() == 0);
  end

  // Transmitter-side monitor: records accepted bytes and checks hold-stability.
  always @(negedge clk) begin
    if (rst) begin
      prev_valid = 1'b0;
      prev_hs    = 1'b0;
    end else begin
      if (fifo_rd_en) rd_pulses++;
      if (prev_valid && !prev_hs) begin
        checks++;
        assert ({tx_valid, tx_data} === {1'b1, prev_data}) else begin
          errors++;
          $error("FAIL tx_hold_stable: observed=%0h expected=%0h", {tx_valid, tx_data}, {1'b1, prev_data});
        end
      end
      if (tx_valid && tx_ready) obs_q.push_back(tx_data);
      prev_valid = tx_valid;
      prev_hs    = tx_valid && tx_ready;
      prev_data  = tx_data;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic wait_valid(input int max);
    int n = 0;
    while (!tx_valid && n < max) begin tick(); n++; end
    chk("wait_tx_valid", tx_valid, 1);
  endtask

  task automatic drain(input int max);
    int n = 0;
    while ((q.size() != 0 || busy || pending) && n < max) begin tick(); n++; end
    chk("drain_done", (q.size() == 0 && !busy), 1);
  endtask

  // One suppressed read; timeout_err must rise exactly TO edges after WAIT_DATA entry.
  task automatic timeout_run(input bit hold_clr);
    int n = 0;
    suppress = 1'b1;
    q.push_back(8'h5A);
    enable = 1'b1;
    while (!fifo_rd_en && n < 20) begin tick(); n++; end
    chk("tmo_rd_en", fifo_rd_en, 1);
    enable  = 1'b0;
    clr_err = hold_clr;
    tick();
    for (int i = 1; i <= TO; i++) begin
      tick();
      chk("tmo_err_timing", timeout_err, (i >= TO) ? 1 : 0);
      chk("tmo_no_tx_valid", tx_valid, 0);
    end
    chk("tmo_back_idle", busy, 0);
    clr_err = 1'b1;
    tick();
    clr_err = 1'b0;
    chk("tmo_clr", timeout_err, 0);
    q.delete();
    suppress = 1'b0;
    tick();
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int r0, o0, bad;
    logic [7:0] b;
    rst = 1'b1; enable = 1'b0; cts_n = 1'b1; tx_ready = 1'b0; clr_err = 1'b0;
    suppress = 1'b0; pending = 1'b0; fifo_empty = 1'b1;
    fifo_rd_valid = 1'b0; fifo_rd_data = 8'h00;
    repeat (3) tick();
    chk("rst_tx_valid", tx_valid, 0);
    chk("rst_tx_data", tx_data, 0);
    chk("rst_rd_en", fifo_rd_en, 0);
    chk("rst_busy", busy, 0);
    chk("rst_count", sent_count, 0);
    chk("rst_err", timeout_err, 0);
    rst = 1'b0;
    tick();

    // Single byte with exact cycle timing
    q.push_back(8'hA5); exp_q.push_back(8'hA5);
    enable = 1'b1; cts_n = 1'b0; tx_ready = 1'b1;
    r0 = rd_pulses;
    tick();
    chk("single_rd_en_hi", fifo_rd_en, 1);
    chk("single_busy", busy, 1);
    tick();
    chk("single_rd_en_lo", fifo_rd_en, 0);
    tick();
    chk("single_tx_valid", tx_valid, 1);
    chk("single_tx_data", tx_data, 8'hA5);
    tick();
    chk("single_valid_drop", tx_valid, 0);
    chk("single_count", sent_count, 1);
    repeat (5) tick();
    chk("single_one_pulse", rd_pulses - r0, 1);

    // Backpressure for 100 cycles
    tx_ready = 1'b0;
    q.push_back(8'h3C); exp_q.push_back(8'h3C);
    q.push_back(8'h11); exp_q.push_back(8'h11);
    r0 = rd_pulses;
    wait_valid(20);
    chk("bp_data", tx_data, 8'h3C);
    repeat (100) tick();
    chk("bp_valid_held", tx_valid, 1);
    chk("bp_data_held", tx_data, 8'h3C);
    chk("bp_no_refetch", rd_pulses - r0, 1);
    chk("bp_count_held", sent_count, 1);
    tx_ready = 1'b1;
    tick();
    chk("bp_count_inc", sent_count, 2);
    drain(50);
    chk("bp_count_final", sent_count, 3);

    // CTS deasserted during SEND of the first of three bytes
    tx_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      b = 8'($urandom);
      q.push_back(b); exp_q.push_back(b);
    end
    wait_valid(20);
    cts_n = 1'b1;
    r0 = rd_pulses;
    o0 = obs_q.size();
    tx_ready = 1'b1;
    repeat (20) tick();
    chk("cts_byte1_done", obs_q.size() - o0, 1);
    chk("cts_no_fetch", rd_pulses - r0, 0);
    chk("cts_idle", busy, 0);
    cts_n = 1'b0;
    drain(100);
    chk("cts_count", sent_count, 6);

    // Read timeouts, including clear colliding with set
    timeout_run(1'b0);
    timeout_run(1'b1);
    enable = 1'b1;

    // Random loopback of 512 bytes; 4-bit counter wraps many times
    for (int i = 0; i < 512; i++) begin
      b = 8'($urandom);
      q.push_back(b); exp_q.push_back(b);
    end
    for (int n = 0; n < 20000 && (q.size() != 0 || busy); n++) begin
      tx_ready = 1'($urandom_range(0, 1));
      cts_n    = ($urandom_range(0, 7) == 0);
      tick();
    end
    cts_n = 1'b0; tx_ready = 1'b1;
    drain(200);
    chk("loop_len", obs_q.size(), exp_q.size());
    bad = 0;
    for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++)
      if (obs_q[i] !== exp_q[i]) bad++;
    chk("loop_sequence", bad, 0);
    chk("loop_count_wrap", sent_count, CW'(exp_q.size() % (1 << CW)));

    // Asynchronous reset while a byte is being offered
    tx_ready = 1'b0;
    q.push_back(8'h99);
    wait_valid(20);
    #2 rst = 1'b1;
    #1;
    chk("arst_tx_valid", tx_valid, 0);
    chk("arst_tx_data", tx_data, 0);
    chk("arst_busy", busy, 0);
    chk("arst_count", sent_count, 0);
    chk("arst_rd_en", fifo_rd_en, 0);
    tick();
    rst = 1'b0;
    enable = 1'b0;
    tick();
    chk("arst_release_idle", busy, 0);
    chk("arst_release_valid", tx_valid, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
